alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 32-bit combinational ALU.
- Same 16-op function map; operand width is generic.
- MUL and DIV are iterative multi-cycle units. All other ops take one cycle.
- Results and flags are registered and held under a valid/ready output handshake, so the block can sit between pipeline stages of the datapath.

---
 rtl/alu_seq.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked, parametrised ALU with iterative MUL/DIV
//
// Purpose:
//   Sixteen-op ALU that accepts one operation at a time over a valid/ready
//   input handshake and holds its registered result and flags under a
//   valid/ready output handshake. MUL (shift-add) and DIV (restoring) run
//   for WIDTH iterations, one bit per cycle. All other ops, and DIV by
//   zero, complete in a single cycle.
//
// Build option:
//   ALU_SIGNED_CMP_EN -- when defined, GT compares signed operands and SHR
//                        becomes an arithmetic shift. Port list is unchanged.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   SHW    shift-amount width, derived from WIDTH (do not override)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands and func are valid
//   in_ready     block can accept a new operation (IDLE only)
//   a, b         operands; b[SHW-1:0] is the shift/rotate amount
//   func         4-bit opcode
//   out_valid    result and flags valid (DONE)
//   out_ready    consumer accepts the result
//   alu_out      registered result
//   carry_out    ADD carry, SUB borrow, MUL high-half-nonzero; 0 otherwise
//   zr_flag      alu_out == 0
//   sign_flag    alu_out MSB
//   parity_flag  even parity of alu_out
//   dbz_flag     DIV with b == 0
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zr_flag,
  output logic             sign_flag,
  output logic             parity_flag,
  output logic             dbz_flag
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  localparam logic [SHW-1:0] CNT_START = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operation and iterative-unit state.
  // r_q holds the multiplier (MUL) or the dividend/quotient (DIV);
  // r_acc holds the partial product high half (MUL) or remainder (DIV).
  logic [3:0]       r_func;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [SHW-1:0]   r_cnt;

  // Registered result and flags presented in DONE.
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_dbz;

  // Single-cycle datapath.
  logic             w_multi;
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_sh_inv;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_dbz;

  // Iterative datapath.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc_next;
  logic [WIDTH-1:0] w_mul_q_next;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_acc_next;
  logic [WIDTH-1:0] w_div_q_next;
  logic             w_is_div;
  logic             w_last_iter;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // MUL always iterates; DIV iterates only for a nonzero divisor.
  assign w_multi = (func == OP_MUL) || ((func == OP_DIV) && (b != '0));

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_multi ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_last_iter) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle operations, evaluated straight from the input operands
  // ---------------------------------------------------------------------------
  assign w_sh     = b[SHW-1:0];
  // WIDTH - amount; equals WIDTH for amount 0, so the wrap-around term of a
  // rotate shifts out completely and the rotate returns a unchanged.
  assign w_sh_inv = (SHW + 1)'(WIDTH) - {1'b0, w_sh};
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};
  assign w_rol    = (a << w_sh) | (a >> w_sh_inv);
  assign w_ror    = (a >> w_sh) | (a << w_sh_inv);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_dbz   = 1'b0;
    case (func)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
      end
      OP_MUL: begin
        w_res = '0;
      end
      OP_DIV: begin
        // Only reaches the result register when b == 0.
        w_res = '1;
        w_dbz = 1'b1;
      end
      OP_SHL: w_res = a << w_sh;
`ifdef ALU_SIGNED_CMP_EN
      OP_SHR: w_res = $unsigned($signed(a) >>> w_sh);
`else
      OP_SHR: w_res = a >> w_sh;
`endif
      OP_OR:   w_res = a | b;
      OP_AND:  w_res = a & b;
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_ROL:  w_res = w_rol;
      OP_ROR:  w_res = w_ror;
`ifdef ALU_SIGNED_CMP_EN
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
`else
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (a > b)};
`endif
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: w_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative MUL / DIV step
  // ---------------------------------------------------------------------------
  assign w_is_div    = (r_func == OP_DIV);
  assign w_last_iter = (r_cnt == '0);

  // Shift-add: conditionally add the multiplicand to the high half, then
  // shift the {high, multiplier} pair right one place. After WIDTH steps
  // {r_acc, r_q} is the full double-width product.
  assign w_mul_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_mul_acc_next = w_mul_sum[WIDTH:1];
  assign w_mul_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};

  // Restoring division: bring the next dividend bit into the remainder and
  // subtract the divisor when it fits. The remainder stays below b, so the
  // shifted value fits in WIDTH+1 bits and the kept difference in WIDTH bits.
  assign w_div_shift    = {r_acc, r_q[WIDTH-1]};
  assign w_div_ok       = (w_div_shift >= {1'b0, r_b});
  assign w_div_acc_next = w_div_ok ? (w_div_shift[WIDTH-1:0] - r_b)
                                   : w_div_shift[WIDTH-1:0];
  assign w_div_q_next   = {r_q[WIDTH-2:0], w_div_ok};

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_func  <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_func <= func;
            r_b    <= b;
            r_q    <= a;
            r_acc  <= '0;
            r_cnt  <= CNT_START;
            if (!w_multi) begin
              r_out   <= w_res;
              r_carry <= w_carry;
              r_dbz   <= w_dbz;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_is_div) begin
            r_acc <= w_div_acc_next;
            r_q   <= w_div_q_next;
          end else begin
            r_acc <= w_mul_acc_next;
            r_q   <= w_mul_q_next;
          end
          if (w_last_iter) begin
            r_dbz <= 1'b0;
            if (w_is_div) begin
              r_out   <= w_div_q_next;
              r_carry <= 1'b0;
            end else begin
              r_out   <= w_mul_q_next;
              r_carry <= |w_mul_acc_next;
            end
          end
        end
        default: begin
          // DONE: result and flags held.
        end
      endcase
    end
  end

  // Flags are pure functions of the registered result, so they change
  // exactly when alu_out does.
  assign alu_out     = r_out;
  assign carry_out   = r_carry;
  assign dbz_flag    = r_dbz;
  assign zr_flag     = (r_out == '0);
  assign sign_flag   = r_out[WIDTH-1];
  assign parity_flag = ~^r_out;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH = 32)
//
// The stimulus process issues directed operations and pushes the
// hand-computed response (result, carry, dbz, latency) into a queue at the
// moment of acceptance. An independent monitor pops an entry each time the
// DUT raises out_valid and compares result, flags and latency.
// Build option ALU_SIGNED_CMP_EN selects the signed GT / arithmetic SHR
// expectations.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   func = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         zr_flag;
  logic         sign_flag;
  logic         parity_flag;
  logic         dbz_flag;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .func        (func),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .carry_out   (carry_out),
    .zr_flag     (zr_flag),
    .sign_flag   (sign_flag),
    .parity_flag (parity_flag),
    .dbz_flag    (dbz_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         carry;
    logic         dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   presenting = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one request and hold it until accepted. Must be called at a
  // falling edge so in_ready reflects the state the next rising edge sees.
  task automatic issue(input string nm, input logic [3:0] f, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] res,
                       input logic c, input logic d, input int lat, input bit push);
    exp_t e;
    int   n;
    func     = f;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: in_ready got 0 expected 1", nm);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.name    = nm;
      e.res     = res;
      e.carry   = c;
      e.dbz     = d;
      e.lat     = lat;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [3:0] f, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [W-1:0] res,
                     input logic c, input logic d, input int lat);
    @(negedge clk);
    issue(nm, f, av, bv, res, c, d, lat, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || presenting) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
  endtask

  // Monitor: compare once per presented result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        presenting = 1'b0;
      end else if (!presenting) begin
        presenting = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got alu_out=%h expected no result", alu_out);
        end else begin
          e = sb.pop_front();
          chk({e.name, " result"}, alu_out, e.res);
          chk({e.name, " carry"}, W'(carry_out), W'(e.carry));
          chk({e.name, " dbz"}, W'(dbz_flag), W'(e.dbz));
          chk({e.name, " zr"}, W'(zr_flag), W'(e.res == '0));
          chk({e.name, " sign"}, W'(sign_flag), W'(e.res[W-1]));
          chk({e.name, " parity"}, W'(parity_flag), W'(~^e.res));
          chk({e.name, " latency"}, W'(cyc - e.acc_cyc), W'(e.lat));
          chk({e.name, " in_ready_low"}, W'(in_ready), '0);
          $display("txn %-10s res=%h carry=%0d dbz=%0d lat=%0d",
                   e.name, alu_out, carry_out, dbz_flag, cyc - e.acc_cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst in_ready", W'(in_ready), W'(1));
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst alu_out", alu_out, '0);
    chk("rst carry", W'(carry_out), W'(0));
    chk("rst dbz", W'(dbz_flag), W'(0));
    chk("rst zr", W'(zr_flag), W'(1));
    chk("rst sign", W'(sign_flag), W'(0));
    chk("rst parity", W'(parity_flag), W'(1));

    // Directed vectors: name, op, a, b, result, carry, dbz, latency
    run("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
    run("add", OP_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1);
    run("sub_brw", OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 1);
    run("sub", OP_SUB, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 1);
    run("mul_ovf", OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33);
    run("mul_7x6", OP_MUL, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 33);
    run("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 33);
    run("div_64_7", OP_DIV, 32'd64, 32'd7, 32'd9, 1'b0, 1'b0, 33);
    run("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1);
    run("div_max3", OP_DIV, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0, 1'b0, 33);
    run("shl", OP_SHL, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1);
`ifdef ALU_SIGNED_CMP_EN
    run("shr", OP_SHR, 32'h80000000, 32'h00000001, 32'hC0000000, 1'b0, 1'b0, 1);
    run("gt_neg", OP_GT, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
`else
    run("shr", OP_SHR, 32'h80000000, 32'h00000001, 32'h40000000, 1'b0, 1'b0, 1);
    run("gt_neg", OP_GT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1);
`endif
    run("or", OP_OR, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1);
    run("and", OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1);
    run("xor", OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1);
    run("xnor", OP_XNOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0FF0F0, 1'b0, 1'b0, 1);
    run("nand", OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
    run("nor", OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    run("rol4", OP_ROL, 32'h80000001, 32'h00000024, 32'h00000018, 1'b0, 1'b0, 1);
    run("ror1", OP_ROR, 32'h00000001, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1);
    run("ror0", OP_ROR, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1);
    run("gt_eq", OP_GT, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);
    run("eq_t", OP_EQ, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1);
    run("eq_f", OP_EQ, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b0, 1);
    drain();

    // Backpressure: hold the result for 5 cycles with a competing request
    @(negedge clk);
    out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1, 1'b1);
    @(negedge clk);
    func     = OP_XOR;
    a        = 32'hAAAAAAAA;
    b        = 32'h55555555;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", W'(out_valid), W'(1));
      chk("bp in_ready", W'(in_ready), W'(0));
      chk("bp hold result", alu_out, 32'h00000003);
      chk("bp hold carry", W'(carry_out), W'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", W'(out_valid), W'(0));
    chk("bp release in_ready", W'(in_ready), W'(1));
    issue("bp_xor", OP_XOR, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b1);
    drain();

    // Reset in cycle 10 of a DIV: result must be discarded
    @(negedge clk);
    issue("abort_div", OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort alu_out", alu_out, '0);
    chk("abort zr", W'(zr_flag), W'(1));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort never valid", W'(seen), W'(0));

    run("post_rst", OP_EQ, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
